// File: rtl/alu_sequencer_if.sv
// Bus between the sequencer and its instruction memory, ALU and register file.
// The master modport is the sequencer side; the slave modport is the datapath side.
interface alu_sequencer_if #(
  parameter int PC_W = 8
);
  logic            imem_en;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_rdata;
  logic [3:0]      alu_op;
  logic [15:0]     alu_out;
  logic [1:0]      alu_branch;
  logic [3:0]      rf_raddr_a;
  logic [3:0]      rf_raddr_b;
  logic [3:0]      rf_raddr_c;
  logic [3:0]      rf_waddr;
  logic            rf_we;
  logic            dmem_we;

  modport master (
    output imem_en, imem_addr, alu_op, rf_raddr_a, rf_raddr_b, rf_raddr_c,
           rf_waddr, rf_we, dmem_we,
    input  imem_rdata, alu_out, alu_branch
  );

  modport slave (
    input  imem_en, imem_addr, alu_op, rf_raddr_a, rf_raddr_b, rf_raddr_c,
           rf_waddr, rf_we, dmem_we,
    output imem_rdata, alu_out, alu_branch
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/WB control unit for the 16-bit ALU; all outputs registered.
// Optional single-step mode (STEP input, PAUSE state) is enabled by defining SEQ_SINGLE_STEP_EN.
module alu_sequencer #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic            step_i,
`endif
  alu_sequencer_if.master bus,
  output logic            busy_o,
  output logic            halted_o,
  output logic            illegal_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
`ifdef SEQ_SINGLE_STEP_EN
    , S_PAUSE
`endif
  } state_e;

  localparam logic [3:0] OP_HALT  = 4'd1;
  localparam logic [3:0] OP_STORE = 4'd6;

  function automatic logic writes_rf(input logic [3:0] op);
    case (op)
      4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd11, 4'd12: return 1'b1;
      default:                                           return 1'b0;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return op >= 4'd13;
  endfunction

  state_e            state_q;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       ir_q;
  logic              imem_en_q, rf_we_q, dmem_we_q;
  logic [3:0]        alu_op_q, raddr_a_q, raddr_b_q, raddr_c_q, waddr_q;
  logic              busy_q, halted_q, illegal_q;
  logic signed [7:0] br_off;
  logic              alu_out_unused;

  assign br_off = ir_q[7:0];
  // Only the low PC_W bits of the ALU result can become a jump target.
  assign alu_out_unused = ^bus.alu_out;

  // Next PC at the end of WB; illegal opcodes are nops and always fall through.
  // NOTE: pc_d gets its default before the case so no latch is inferred.
  always_comb begin
    pc_d = pc_q + 1'b1;
    if (!is_illegal(ir_q[15:12])) begin
      case (bus.alu_branch)
        2'b01:   pc_d = pc_q + PC_W'(br_off);
        2'b10:   pc_d = bus.alu_out[PC_W-1:0];
        default: pc_d = pc_q + 1'b1;
      endcase
    end
  end

  // NOTE: all state and outputs update with non-blocking assignments so every
  // register sees the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= START_PC;
      ir_q      <= '0;
      imem_en_q <= 1'b0;
      rf_we_q   <= 1'b0;
      dmem_we_q <= 1'b0;
      alu_op_q  <= '0;
      raddr_a_q <= '0;
      raddr_b_q <= '0;
      raddr_c_q <= '0;
      waddr_q   <= '0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      imem_en_q <= 1'b0;
      rf_we_q   <= 1'b0;
      dmem_we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_HALT: begin
          if (start_i) begin
            state_q   <= S_FETCH;
            pc_q      <= START_PC;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
            busy_q    <= 1'b1;
            imem_en_q <= 1'b1;
          end
        end
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          ir_q <= bus.imem_rdata;
          // Halt is recognised straight off the memory data, skipping EXEC/WB.
          if (bus.imem_rdata[15:12] == OP_HALT) begin
            state_q  <= S_HALT;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            state_q   <= S_EXEC;
            alu_op_q  <= bus.imem_rdata[15:12];
            raddr_a_q <= bus.imem_rdata[11:8];
            raddr_b_q <= bus.imem_rdata[7:4];
            raddr_c_q <= bus.imem_rdata[3:0];
            if (is_illegal(bus.imem_rdata[15:12])) illegal_q <= 1'b1;
          end
        end
        S_EXEC: begin
          state_q <= S_WB;
          if (writes_rf(ir_q[15:12])) begin
            rf_we_q <= 1'b1;
            waddr_q <= ir_q[11:8];
          end
          if (ir_q[15:12] == OP_STORE) dmem_we_q <= 1'b1;
        end
        S_WB: begin
          pc_q      <= pc_d;
          alu_op_q  <= '0;
          raddr_a_q <= '0;
          raddr_b_q <= '0;
          raddr_c_q <= '0;
          waddr_q   <= '0;
`ifdef SEQ_SINGLE_STEP_EN
          state_q   <= S_PAUSE;
          busy_q    <= 1'b0;
`else
          state_q   <= S_FETCH;
          imem_en_q <= 1'b1;
`endif
        end
`ifdef SEQ_SINGLE_STEP_EN
        S_PAUSE: begin
          if (step_i) begin
            state_q   <= S_FETCH;
            busy_q    <= 1'b1;
            imem_en_q <= 1'b1;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.imem_en    = imem_en_q;
  assign bus.imem_addr  = pc_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.rf_raddr_a = raddr_a_q;
  assign bus.rf_raddr_b = raddr_b_q;
  assign bus.rf_raddr_c = raddr_c_q;
  assign bus.rf_waddr   = waddr_q;
  assign bus.rf_we      = rf_we_q;
  assign bus.dmem_we    = dmem_we_q;
  assign busy_o         = busy_q;
  assign halted_o       = halted_q;
  assign illegal_o      = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer: instruction memory model plus
// hand-computed expectations for write-back, branching, halt, illegal ops and reset abort.
module tb_alu_sequencer;

  logic clk;
  logic rst_n;
  logic start;
  logic busy, halted, illegal;

  alu_sequencer_if #(.PC_W(8)) bus_if ();

  alu_sequencer #(.PC_W(8), .START_PC(8'h00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start),
`ifdef SEQ_SINGLE_STEP_EN
    .step_i    (1'b1),
`endif
    .bus       (bus_if),
    .busy_o    (busy),
    .halted_o  (halted),
    .illegal_o (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: data valid the cycle after imem_en.
  logic [15:0] imem [256];
  always @(posedge clk) begin
    if (bus_if.imem_en) bus_if.imem_rdata <= imem[bus_if.imem_addr];
  end

  // Strobe monitor; counters only grow, tests compare deltas.
  int n_rf, n_dm, n_both;
  initial begin
    n_rf = 0;
    n_dm = 0;
    n_both = 0;
  end
  always @(negedge clk) begin
    if (bus_if.rf_we)                  n_rf   <= n_rf + 1;
    if (bus_if.dmem_we)                n_dm   <= n_dm + 1;
    if (bus_if.rf_we && bus_if.dmem_we) n_both <= n_both + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge inside the FETCH cycle.
  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halted;
    int n;
    n = 0;
    while (!halted && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("halt_wait", {31'd0, halted}, 32'd1);
  endtask

  int rf0, dm0;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bus_if.alu_out    = 16'h0000;
    bus_if.alu_branch = 2'b00;
    for (int i = 0; i < 256; i++) imem[i] = 16'h1000;

    step(2);
    rst_n = 1'b1;
    step(1);
    check("rst_busy",    {31'd0, busy},           32'd0);
    check("rst_halted",  {31'd0, halted},         32'd0);
    check("rst_illegal", {31'd0, illegal},        32'd0);
    check("rst_imem_en", {31'd0, bus_if.imem_en}, 32'd0);
    check("rst_pc",      {24'd0, bus_if.imem_addr}, 32'h00);
    check("rst_alu_op",  {28'd0, bus_if.alu_op},  32'd0);
    check("rst_rf_we",   {31'd0, bus_if.rf_we},   32'd0);

    // Register write: op 2, rd=1, rb=2, rc=3
    imem[0] = 16'h2123;
    imem[1] = 16'h1000;
    rf0 = n_rf;
    pulse_start;
    check("t1_fetch_en",   {31'd0, bus_if.imem_en},   32'd1);
    check("t1_fetch_addr", {24'd0, bus_if.imem_addr}, 32'h00);
    check("t1_busy",       {31'd0, busy},             32'd1);
    step(2);
    check("t1_exec_op",    {28'd0, bus_if.alu_op},    32'd2);
    check("t1_exec_rfwe",  {31'd0, bus_if.rf_we},     32'd0);
    step(1);
    check("t1_wb_rfwe",    {31'd0, bus_if.rf_we},     32'd1);
    check("t1_wb_waddr",   {28'd0, bus_if.rf_waddr},  32'd1);
    check("t1_wb_op",      {28'd0, bus_if.alu_op},    32'd2);
    check("t1_wb_ra",      {28'd0, bus_if.rf_raddr_a}, 32'd1);
    check("t1_wb_rb",      {28'd0, bus_if.rf_raddr_b}, 32'd2);
    check("t1_wb_rc",      {28'd0, bus_if.rf_raddr_c}, 32'd3);
    check("t1_wb_dmwe",    {31'd0, bus_if.dmem_we},   32'd0);
    step(1);
    check("t1_next_pc",    {24'd0, bus_if.imem_addr}, 32'h01);
    check("t1_next_rfwe",  {31'd0, bus_if.rf_we},     32'd0);
    check("t1_next_op",    {28'd0, bus_if.alu_op},    32'd0);
    wait_halted;
    check("t1_rf_pulses",  n_rf - rf0,                32'd1);

    // Relative branch -2 from 0 wraps to FE, +1 to FF, then fall-through wraps to 0
    imem[8'h00] = 16'h50FE;
    imem[8'hFE] = 16'h5001;
    imem[8'hFF] = 16'h5000;
    bus_if.alu_branch = 2'b01;
    rf0 = n_rf;
    dm0 = n_dm;
    pulse_start;
    step(4);
    check("t2_pc_fe", {24'd0, bus_if.imem_addr}, 32'hFE);
    step(4);
    check("t2_pc_ff", {24'd0, bus_if.imem_addr}, 32'hFF);
    bus_if.alu_branch = 2'b00;
    step(4);
    check("t2_pc_wrap", {24'd0, bus_if.imem_addr}, 32'h00);
    imem[0] = 16'h1000;
    wait_halted;
    check("t2_no_rf", n_rf - rf0, 32'd0);
    check("t2_no_dm", n_dm - dm0, 32'd0);

    // Store with absolute jump through ALU_OUT
    imem[0] = 16'h6000;
    bus_if.alu_out    = 16'h0010;
    bus_if.alu_branch = 2'b10;
    rf0 = n_rf;
    dm0 = n_dm;
    pulse_start;
    step(3);
    check("t3_wb_dmwe", {31'd0, bus_if.dmem_we}, 32'd1);
    check("t3_wb_rfwe", {31'd0, bus_if.rf_we},   32'd0);
    step(1);
    check("t3_jump_pc", {24'd0, bus_if.imem_addr}, 32'h10);
    check("t3_dm_drop", {31'd0, bus_if.dmem_we}, 32'd0);
    wait_halted;
    check("t3_dm_pulses", n_dm - dm0, 32'd1);
    check("t3_rf_pulses", n_rf - rf0, 32'd0);
    bus_if.alu_out    = 16'h0000;
    bus_if.alu_branch = 2'b00;

    // Halt: two cycles from FETCH to HALTED, then restart from START_PC
    imem[0] = 16'h1000;
    rf0 = n_rf;
    dm0 = n_dm;
    pulse_start;
    check("t4_fetch_halted", {31'd0, halted}, 32'd0);
    step(1);
    check("t4_decode_halted", {31'd0, halted}, 32'd0);
    step(1);
    check("t4_halted",  {31'd0, halted},          32'd1);
    check("t4_busy",    {31'd0, busy},            32'd0);
    check("t4_imem_en", {31'd0, bus_if.imem_en},  32'd0);
    check("t4_alu_op",  {28'd0, bus_if.alu_op},   32'd0);
    pulse_start;
    check("t4_restart_halted", {31'd0, halted},           32'd0);
    check("t4_restart_busy",   {31'd0, busy},             32'd1);
    check("t4_restart_pc",     {24'd0, bus_if.imem_addr}, 32'h00);
    wait_halted;
    check("t4_no_strobes", (n_rf - rf0) + (n_dm - dm0), 32'd0);

    // Illegal opcode: sticky flag, nop with PC+1 even under BRANCH=01
    imem[0] = 16'hE000;
    imem[1] = 16'h2000;
    imem[2] = 16'h1000;
    bus_if.alu_branch = 2'b01;
    rf0 = n_rf;
    pulse_start;
    step(2);
    check("t5_illegal_set", {31'd0, illegal},      32'd1);
    step(1);
    check("t5_nop_rfwe",    {31'd0, bus_if.rf_we}, 32'd0);
    step(1);
    check("t5_nop_pc",      {24'd0, bus_if.imem_addr}, 32'h01);
    bus_if.alu_branch = 2'b00;
    step(3);
    check("t5_next_rfwe",   {31'd0, bus_if.rf_we},    32'd1);
    check("t5_next_waddr",  {28'd0, bus_if.rf_waddr}, 32'd0);
    check("t5_sticky",      {31'd0, illegal},         32'd1);
    wait_halted;
    check("t5_sticky_halt", {31'd0, illegal},         32'd1);
    pulse_start;
    check("t5_cleared",     {31'd0, illegal},         32'd0);
    wait_halted;
    check("t5_rf_pulses",   n_rf - rf0,               32'd2);

    // Reset during EXEC aborts with no write and leaves the block idle
    imem[0] = 16'h3456;
    rf0 = n_rf;
    pulse_start;
    step(2);
    check("t6_exec_op", {28'd0, bus_if.alu_op}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy",   {31'd0, busy},              32'd0);
    check("t6_rst_op",     {28'd0, bus_if.alu_op},     32'd0);
    check("t6_rst_rfwe",   {31'd0, bus_if.rf_we},      32'd0);
    check("t6_rst_ra",     {28'd0, bus_if.rf_raddr_a}, 32'd0);
    check("t6_rst_halted", {31'd0, halted},            32'd0);
    check("t6_rst_pc",     {24'd0, bus_if.imem_addr},  32'h00);
    step(2);
    rst_n = 1'b1;
    step(6);
    check("t6_idle_busy",  {31'd0, busy},           32'd0);
    check("t6_idle_en",    {31'd0, bus_if.imem_en}, 32'd0);
    check("t6_no_rf",      n_rf - rf0,              32'd0);
    pulse_start;
    check("t6_start_busy", {31'd0, busy},              32'd1);
    check("t6_start_pc",   {24'd0, bus_if.imem_addr},  32'h00);
    wait_halted;

    check("strobe_exclusive", n_both, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
